// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word reads,
// buffers returned words with their PC and hands them to the core.
// Credit scheme: a request issues only when every outstanding live response
// is guaranteed a buffer slot. Responses from before a redirect are counted in
// drop and discarded as they return.
module instr_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   CREDIT   = (CW + 1)'(FIFO_DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [PW-1:0] fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic          rst_done_q, rst_done_d;

  logic [63:0]   pq_pc_q   [FIFO_DEPTH];
  logic [63:0]   pq_pc_d   [FIFO_DEPTH];
  logic [63:0]   fq_pc_q   [FIFO_DEPTH];
  logic [63:0]   fq_pc_d   [FIFO_DEPTH];
  logic [31:0]   fq_data_q [FIFO_DEPTH];
  logic [31:0]   fq_data_d [FIFO_DEPTH];

  logic [CW:0]   used;
  logic          has_credit;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_take;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Issue gating: rst_done_q holds requests off for the cycle after reset.
  assign used       = {1'b0, inflight_q} + {1'b0, count_q};
  assign has_credit = used < CREDIT;

  assign imem_req_valid = rst_n && rst_done_q && !redirect_valid && has_credit;
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = rst_n && (count_q != '0);
  assign instr          = fq_data_q[fq_rd_q];
  assign instr_pc       = fq_pc_q[fq_rd_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_take = imem_rsp_valid && (drop_q == '0) && (inflight_q != '0);
  assign pop      = instr_valid && instr_ready;

  // Next-state: redirect flushes everything; otherwise issue, accept and pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;
    rst_done_d = 1'b1;
    pq_pc_d    = pq_pc_q;
    fq_pc_d    = fq_pc_q;
    fq_data_d  = fq_data_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      inflight_d = '0;
      count_d    = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
      fq_wr_d    = '0;
      fq_rd_d    = '0;
      // A response landing this cycle retires one outstanding request first.
      drop_d     = drop_q + inflight_q - ((rsp_drop || rsp_take) ? CNT_ONE : '0);
    end else begin
      if (req_fire) begin
        pq_pc_d[pq_wr_q] = fetch_pc_q;
        pq_wr_d          = ptr_inc(pq_wr_q);
        fetch_pc_d       = fetch_pc_q + 64'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CNT_ONE;
      end
      if (rsp_take) begin
        fq_data_d[fq_wr_q] = imem_rsp_data;
        fq_pc_d[fq_wr_q]   = pq_pc_q[pq_rd_q];
        fq_wr_d            = ptr_inc(fq_wr_q);
        pq_rd_d            = ptr_inc(pq_rd_q);
      end
      if (pop) begin
        fq_rd_d = ptr_inc(fq_rd_q);
      end
      inflight_d = inflight_q + (req_fire ? CNT_ONE : '0) - (rsp_take ? CNT_ONE : '0);
      count_d    = count_q + (rsp_take ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      rst_done_q <= rst_done_d;
    end
  end

  // Buffer storage; validity is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    pq_pc_q   <= pq_pc_d;
    fq_pc_q   <= fq_pc_d;
    fq_data_q <= fq_data_d;
  end

  // A response with nothing outstanding means the memory broke protocol.
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (drop_q != '0 || inflight_q != '0));

  // Credit check must keep the buffer from ever overfilling.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CW'(FIFO_DEPTH));

endmodule
